// File: rtl/ex_issue_ctrl_if.sv
// ID/EX latch to execute-stage issue interface: decoded op in, stall/issue back, writeback tag and FU busy out.
interface ex_issue_ctrl_if #(
    parameter int ROB_ID_W = 5,
    parameter int DEST_W   = 6,
    parameter int NUM_FU   = 5
);
    logic                flush;
    logic                in_ins_nop;
    logic [2:0]          in_func_select;
    logic [3:0]          in_latency;
    logic [ROB_ID_W-1:0] in_ins_id;
    logic [DEST_W-1:0]   in_dest_addr;
    logic                stall;
    logic                issue;
    logic                wb_valid;
    logic [ROB_ID_W-1:0] wb_ins_id;
    logic [DEST_W-1:0]   wb_dest_addr;
    logic [NUM_FU-1:0]   fu_busy;

    modport master (
        output flush, in_ins_nop, in_func_select, in_latency, in_ins_id, in_dest_addr,
        input  stall, issue, wb_valid, wb_ins_id, wb_dest_addr, fu_busy
    );

    modport slave (
        input  flush, in_ins_nop, in_func_select, in_latency, in_ins_id, in_dest_addr,
        output stall, issue, wb_valid, wb_ins_id, wb_dest_addr, fu_busy
    );
endinterface

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue control: FU occupancy, single result-bus slot tracking, fixed-latency wb tags.
// Defining ISSUE_STATS_EN adds saturating stat_issued / stat_stall_cycles counters.
module ex_issue_ctrl #(
    parameter int ROB_ID_W = 5,
    parameter int DEST_W   = 6,
    parameter int NUM_FU   = 5,
    parameter int MAX_LAT  = 15,
    parameter logic [NUM_FU-1:0] PIPE_MASK = 5'b00011
) (
    input  logic           clk,
    input  logic           reset,
    ex_issue_ctrl_if.slave bus
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]    stat_issued,
    output logic [31:0]    stat_stall_cycles
`endif
);
    typedef struct packed {
        logic                v;
        logic [ROB_ID_W-1:0] id;
        logic [DEST_W-1:0]   dest;
    } slot_t;

    slot_t      slot    [MAX_LAT];
    slot_t      slot_sh [MAX_LAT];
    logic [3:0] busy_cnt [NUM_FU];
    logic [NUM_FU-1:0] fu_busy;
    int   lat;
    int   fsel;
    logic sel_busy;
    logic conflict;
    logic stall;
    logic issue;

    always_comb begin
        lat = int'(bus.in_latency);
        if (lat == 0) lat = 1;
        if (lat > MAX_LAT) lat = MAX_LAT;
        fsel = int'(bus.in_func_select);
    end

    // Out-of-range func_select matches no FU, so it behaves as pipelined.
    always_comb begin
        sel_busy = 1'b0;
        fu_busy  = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_busy[f] = (busy_cnt[f] != 4'd0);
            if (fsel == f && busy_cnt[f] != 4'd0) sel_busy = 1'b1;
        end
        // slot[L] shifts down to L-1 at this edge; L==MAX_LAT never matches.
        conflict = 1'b0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (lat == k && slot[k].v) conflict = 1'b1;
        end
    end

    assign stall = !bus.in_ins_nop && (sel_busy || conflict);
    assign issue = !bus.in_ins_nop && !stall && !bus.flush && !reset;

    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) slot_sh[k] = slot[k + 1];
        slot_sh[MAX_LAT - 1] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int k = 0; k < MAX_LAT; k++) slot[k] <= '0;
            for (int f = 0; f < NUM_FU; f++) busy_cnt[f] <= 4'd0;
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (issue && k == lat - 1)
                    slot[k] <= '{v: 1'b1, id: bus.in_ins_id, dest: bus.in_dest_addr};
                else
                    slot[k] <= slot_sh[k];
            end
            for (int f = 0; f < NUM_FU; f++) begin
                if (issue && fsel == f && !PIPE_MASK[f])
                    busy_cnt[f] <= 4'(lat - 1);
                else if (busy_cnt[f] != 4'd0)
                    busy_cnt[f] <= busy_cnt[f] - 4'd1;
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.issue        = issue;
    assign bus.wb_valid     = slot[0].v;
    assign bus.wb_ins_id    = slot[0].id;
    assign bus.wb_dest_addr = slot[0].dest;
    assign bus.fu_busy      = fu_busy;

`ifdef ISSUE_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued       <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (issue && stat_issued != 32'hFFFF_FFFF)
                stat_issued <= stat_issued + 32'd1;
            if (stall && stat_stall_cycles != 32'hFFFF_FFFF)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Scoreboard bench for ex_issue_ctrl: expected wb tags queued at issue, matched against the result bus every cycle.
module tb_ex_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_iss = 0;
    int   n_stl = 0;

    typedef struct {
        int         c;
        logic [4:0] id;
        logic [5:0] dest;
    } exp_t;
    exp_t sb[$];

    ex_issue_ctrl_if #(.ROB_ID_W(5), .DEST_W(6), .NUM_FU(5)) bus ();

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall_cycles;
`endif

    ex_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One cycle: drive after the edge, check stall/issue mid-cycle, queue the expected wb tag.
    task automatic step(input logic nop, input logic [2:0] fs, input logic [3:0] lat,
                        input logic [4:0] id, input logic [5:0] dest, input logic fl,
                        input logic rs, input logic es, input logic ei);
        @(posedge clk);
        #1;
        bus.in_ins_nop     = nop;
        bus.in_func_select = fs;
        bus.in_latency     = lat;
        bus.in_ins_id      = id;
        bus.in_dest_addr   = dest;
        bus.flush          = fl;
        reset              = rs;
        @(negedge clk);
        check("stall", 32'(bus.stall), 32'(es));
        check("issue", 32'(bus.issue), 32'(ei));
        if (ei) sb.push_back('{cyc + ((lat == 4'd0) ? 1 : int'(lat)), id, dest});
        if (fl) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].c > cyc) sb.delete(i);
        end
        if (!rs) begin
            if (es) n_stl++;
            if (ei) n_iss++;
        end
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 3'd0, 4'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Result-bus monitor: each cycle either the scheduled tag appears or the bus is idle.
    initial begin
        int hit;
        @(posedge clk);
        forever begin
            @(negedge clk);
            hit = -1;
            foreach (sb[i]) if (sb[i].c == cyc) hit = i;
            if (hit >= 0) begin
                check("wb_valid", 32'(bus.wb_valid), 32'd1);
                check("wb_ins_id", 32'(bus.wb_ins_id), 32'(sb[hit].id));
                check("wb_dest_addr", 32'(bus.wb_dest_addr), 32'(sb[hit].dest));
                sb.delete(hit);
            end else begin
                check("wb_idle", 32'(bus.wb_valid), 32'd0);
            end
        end
    end

    initial begin
        bus.flush = 1'b0;
        bus.in_ins_nop = 1'b1;
        bus.in_func_select = 3'd0;
        bus.in_latency = 4'd0;
        bus.in_ins_id = 5'd0;
        bus.in_dest_addr = 6'd0;

        // Reset held 2 cycles with a valid op presented
        step(1'b0, 3'd0, 4'd4, 5'd3, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_fu_busy", 32'(bus.fu_busy), 32'd0);
        step(1'b0, 3'd2, 4'd4, 5'd3, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_wb_id", 32'(bus.wb_ins_id), 32'd0);
        check("rst_wb_dest", 32'(bus.wb_dest_addr), 32'd0);
        check("rst_fu_busy2", 32'(bus.fu_busy), 32'd0);

        // Fixed latency 4, then latency 0 treated as 1
        step(1'b0, 3'd0, 4'd4, 5'd3, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(5);
        step(1'b0, 3'd0, 4'd0, 5'd7, 6'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(2);

        // Result-bus conflict: L=3 then L=2 must wait one cycle
        step(1'b0, 3'd0, 4'd3, 5'd1, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd1, 4'd2, 5'd2, 6'd13, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd1, 4'd2, 5'd2, 6'd13, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(3);

        // Non-pipelined FU2 occupancy, pipelined FU0 unaffected
        step(1'b0, 3'd2, 4'd5, 5'd4, 6'd14, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fu_busy_t0", 32'(bus.fu_busy), 32'd0);
        step(1'b0, 3'd0, 4'd1, 5'd5, 6'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fu_busy_t1", 32'(bus.fu_busy), 32'b00100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd2, 4'd1, 5'd6, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0);
            check("fu_busy_hold", 32'(bus.fu_busy), 32'b00100);
        end
        // Issue coincides with wb of the FU2 op
        step(1'b0, 3'd2, 4'd1, 5'd6, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fu_busy_free", 32'(bus.fu_busy), 32'd0);
        // Non-pipelined L=1 back to back
        step(1'b0, 3'd3, 4'd1, 5'd8, 6'd17, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd3, 4'd1, 5'd9, 6'd18, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fu_busy_l1", 32'(bus.fu_busy), 32'd0);
        bubble(2);

        // func_select beyond NUM_FU is never busy-tracked
        step(1'b0, 3'd6, 4'd3, 5'd20, 6'd19, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd6, 4'd1, 5'd21, 6'd20, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fu_busy_oob", 32'(bus.fu_busy), 32'd0);
        bubble(4);

        // Flush with three ops in flight and a valid op presented
        step(1'b0, 3'd0, 4'd8, 5'd10, 6'd21, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd1, 4'd9, 5'd11, 6'd22, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd4, 4'd10, 5'd12, 6'd23, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fu_busy_pre_flush", 32'(bus.fu_busy), 32'd0);
        step(1'b0, 3'd0, 4'd2, 5'd13, 6'd24, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fu_busy_at_flush", 32'(bus.fu_busy), 32'b10000);
        bubble(1);
        check("fu_busy_post_flush", 32'(bus.fu_busy), 32'd0);
        bubble(14);
        step(1'b0, 3'd4, 4'd2, 5'd14, 6'd25, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(3);

        // Max latency: L=15 never conflicts, but blocks L=14 behind it
        step(1'b0, 3'd0, 4'd15, 5'd15, 6'd26, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd1, 4'd14, 5'd16, 6'd27, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd1, 4'd14, 5'd16, 6'd27, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 4'd15, 5'd17, 6'd28, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(17);

        check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef ISSUE_STATS_EN
        check("stat_issued", stat_issued, 32'(n_iss));
        check("stat_stall_cycles", stat_stall_cycles, 32'(n_stl));
`endif
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
